// File: rtl/game_pkg.sv
// Shared types and constants for the whack-a-box game controller.
// Includes the target pick rule used when a new box is lit.
package game_pkg;

    typedef enum logic [2:0] {
        ST_LOBBY     = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_HIT  = 3'd2,
        ST_HIT       = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam logic [2:0]  MIF_LOBBY    = 3'd0;
    localparam logic [2:0]  MIF_GAMEOVER = 3'd7;
    localparam logic [2:0]  BOX_NONE     = 3'd0;
    localparam logic [2:0]  BOX_INVALID  = 3'd7;
    localparam int          NUM_BOXES    = 6;
    localparam logic [10:0] SCORE_MAX    = 11'd2047;
    localparam logic [7:0]  LFSR_SEED    = 8'hA5;

    // Unusable or repeated candidates fall back to the next box in rotation.
    function automatic logic [2:0] pick_target(input logic [2:0] cand, input logic [2:0] cur);
        logic [2:0] nxt;
        nxt = (cur == 3'(NUM_BOXES)) ? 3'd1 : cur + 3'd1;
        if (cand == BOX_NONE || cand == BOX_INVALID || cand == cur)
            return nxt;
        return cand;
    endfunction

endpackage

// File: rtl/target_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used as the target source.
module target_lfsr
    import game_pkg::*;
(
    input  logic       clk_i,
    input  logic       resetn_i,
    output logic [7:0] state_o
);

    logic [7:0] state_q;
    logic [7:0] state_d;

    always_comb begin
        state_d = {state_q[6:0], state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3]};
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i)
            state_q <= LFSR_SEED;
        else
            state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/game_controller.sv
// Game sequencer: lobby, timed rounds of lit targets scored from the sensor boxes, game over.
// Every output comes straight from a flop.
module game_controller
    import game_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int GAME_SECONDS = 60,
    parameter int TARGET_TICKS = 2
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start_game,
    input  logic [2:0]  box_address,
    output logic [2:0]  mif_control_signal,
    output logic [10:0] score,
    output logic [5:0]  game_timer,
    output logic        play_sound,
    output logic        lobby_sound,
    output logic        game_active
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TT_W   = (TARGET_TICKS > 1) ? $clog2(TARGET_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TT_W-1:0]   TT_LAST   = TT_W'(TARGET_TICKS - 1);
    localparam logic [5:0]        GAME_LEN  = 6'(GAME_SECONDS);

    state_t            state_q, state_d;
    logic              start_q;
    logic [2:0]        box_prev_q;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [5:0]        timer_q, timer_d;
    logic [10:0]       score_q, score_d;
    logic [2:0]        target_q, target_d;
    logic [2:0]        mif_q, mif_d;
    logic              play_q, play_d;
    logic              lobby_q, lobby_d;
    logic              active_q, active_d;
    logic [7:0]        lfsr;
    logic              lfsr_hi_unused;
    logic              start_edge, hit_ev, is_active, tick_wrap;

    function automatic logic [10:0] sat_inc(input logic [10:0] s);
        return (s == SCORE_MAX) ? s : s + 11'd1;
    endfunction

    function automatic logic [10:0] sat_dec(input logic [10:0] s);
        return (s == 11'd0) ? s : s - 11'd1;
    endfunction

    target_lfsr u_lfsr (
        .clk_i    (CLOCK_50),
        .resetn_i (resetn),
        .state_o  (lfsr)
    );

    assign lfsr_hi_unused = ^lfsr[7:3];

    assign start_edge = start_game & ~start_q;
    assign hit_ev     = (box_address != BOX_NONE) && (box_address != BOX_INVALID)
                        && (box_address != box_prev_q);
    assign is_active  = (state_q == ST_ARM) || (state_q == ST_WAIT_HIT) || (state_q == ST_HIT);
    assign tick_wrap  = is_active && (tick_q == TICK_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q    <= ST_LOBBY;
            start_q    <= 1'b0;
            box_prev_q <= BOX_NONE;
            tick_q     <= '0;
            tt_q       <= '0;
            timer_q    <= GAME_LEN;
            score_q    <= '0;
            target_q   <= BOX_NONE;
            mif_q      <= MIF_LOBBY;
            play_q     <= 1'b0;
            lobby_q    <= 1'b1;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_game;
            box_prev_q <= box_address;
            tick_q     <= tick_d;
            tt_q       <= tt_d;
            timer_q    <= timer_d;
            score_q    <= score_d;
            target_q   <= target_d;
            mif_q      <= mif_d;
            play_q     <= play_d;
            lobby_q    <= lobby_d;
            active_q   <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        tt_d     = tt_q;
        timer_d  = timer_q;
        score_d  = score_q;
        target_d = target_q;
        play_d   = 1'b0;
        if (is_active) begin
            tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
            if (tick_wrap && timer_q != 6'd0)
                timer_d = timer_q - 6'd1;
        end
        unique case (state_q)
            ST_LOBBY: begin
                if (start_edge) begin
                    state_d = ST_ARM;
                    score_d = '0;
                    timer_d = GAME_LEN;
                    tick_d  = '0;
                end
            end
            ST_ARM: begin
                target_d = pick_target(lfsr[2:0], target_q);
                tt_d     = '0;
                state_d  = ST_WAIT_HIT;
            end
            ST_WAIT_HIT: begin
                if (hit_ev && box_address == target_q) begin
                    score_d = sat_inc(score_q);
                    play_d  = 1'b1;
                    state_d = ST_HIT;
                end else begin
                    if (hit_ev)
                        score_d = sat_dec(score_q);
                    if (tick_wrap) begin
                        if (tt_q == TT_LAST)
                            state_d = ST_ARM;
                        else
                            tt_d = tt_q + TT_W'(1);
                    end
                end
            end
            ST_HIT:       state_d = ST_ARM;
            ST_GAME_OVER: if (start_edge) state_d = ST_LOBBY;
            default:      state_d = ST_LOBBY;
        endcase
        // Time-out wins over any transition, but a hit scored this edge stands.
        if (is_active && timer_q == 6'd0)
            state_d = ST_GAME_OVER;
    end

    always_comb begin
        mif_d    = MIF_LOBBY;
        lobby_d  = 1'b0;
        active_d = 1'b0;
        unique case (state_d)
            ST_LOBBY:     lobby_d = 1'b1;
            ST_GAME_OVER: mif_d   = MIF_GAMEOVER;
            default: begin
                mif_d    = target_d;
                active_d = 1'b1;
            end
        endcase
    end

    assign mif_control_signal = mif_q;
    assign score              = score_q;
    assign game_timer         = timer_q;
    assign play_sound         = play_q;
    assign lobby_sound        = lobby_q;
    assign game_active        = active_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: vector table plus hand-written corner sequences.
module tb_game_controller;

    localparam int TGT = 8;   // box code: press the current lit target
    localparam int WRG = 9;   // box code: press a box that is not the target
    localparam int HLD = 10;  // box code: keep the previous box value
    localparam int MT  = 8;   // mif code: expect the current target

    typedef struct {
        bit rst_n;
        bit start;
        int box;
        bit arm;
        int mif;
        int sc;
        int tm;
        bit play;
        bit lobby;
        bit act;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_game = 1'b0;
    logic [2:0]  box_address = 3'd0;
    logic [2:0]  mif_control_signal;
    logic [10:0] score;
    logic [5:0]  game_timer;
    logic        play_sound, lobby_sound, game_active;

    int checks = 0;
    int failures = 0;
    logic [7:0] m_lfsr = 8'hA5;
    logic [2:0] m_target = 3'd0;
    vec_t tbl[$];

    game_controller #(.TICK_DIV(4), .GAME_SECONDS(3), .TARGET_TICKS(2)) dut (
        .CLOCK_50           (clk),
        .resetn             (resetn),
        .start_game         (start_game),
        .box_address        (box_address),
        .mif_control_signal (mif_control_signal),
        .score              (score),
        .game_timer         (game_timer),
        .play_sound         (play_sound),
        .lobby_sound        (lobby_sound),
        .game_active        (game_active)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [2:0] pick(input logic [7:0] l, input logic [2:0] cur);
        logic [2:0] c;
        c = l[2:0];
        if (c == 3'd0 || c == 3'd7 || c == cur) begin
            if (cur == 3'd6) return 3'd1;
            return cur + 3'd1;
        end
        return c;
    endfunction

    task automatic add(input bit r, input bit s, input int b, input bit a, input int m,
                       input int sc, input int tm, input bit p, input bit l, input bit ac);
        vec_t v;
        v = '{r, s, b, a, m, sc, tm, p, l, ac};
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, clock once, keep the reference LFSR/target in step.
    task automatic cyc(input bit r, input bit s, input int bc, input bit arm);
        resetn = r;
        start_game = s;
        if (bc == TGT)
            box_address = m_target;
        else if (bc == WRG)
            box_address = (m_target == 3'd6) ? 3'd1 : m_target + 3'd1;
        else if (bc != HLD)
            box_address = 3'(bc);
        if (arm)
            m_target = pick(m_lfsr, m_target);
        @(posedge clk);
        m_lfsr = r ? lfsr_next(m_lfsr) : 8'hA5;
        if (!r)
            m_target = 3'd0;
        #1;
    endtask

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chk(input string nm, input int m, input int sc, input int tm,
                       input bit p, input bit l, input bit ac);
        int em;
        em = (m == MT) ? int'(m_target) : m;
        cmp({nm, "_mif"}, int'(mif_control_signal), em);
        cmp({nm, "_score"}, int'(score), sc);
        cmp({nm, "_timer"}, int'(game_timer), tm);
        cmp({nm, "_play"}, int'(play_sound), int'(p));
        cmp({nm, "_lobby"}, int'(lobby_sound), int'(l));
        cmp({nm, "_active"}, int'(game_active), int'(ac));
    endtask

    initial begin
        // reset and idle lobby (box 3 in lobby is ignored)
        add(0,0,0,0,   0,0,3,0,1,0);
        add(0,0,0,0,   0,0,3,0,1,0);
        add(1,0,0,0,   0,0,3,0,1,0);
        add(1,0,3,0,   0,0,3,0,1,0);
        add(1,0,0,0,   0,0,3,0,1,0);
        // game A: held correct box scores once, invalid box 7 ignored
        add(1,1,0,0,   MT,0,3,0,0,1);
        add(1,0,0,1,   MT,0,3,0,0,1);
        add(1,0,TGT,0, MT,1,3,1,0,1);
        add(1,0,HLD,0, MT,1,3,0,0,1);
        add(1,0,HLD,1, MT,1,2,0,0,1);
        add(1,0,HLD,0, MT,1,2,0,0,1);
        add(1,0,HLD,0, MT,1,2,0,0,1);
        add(1,0,7,0,   MT,1,2,0,0,1);
        add(1,0,0,0,   MT,1,1,0,0,1);
        add(1,0,0,0,   MT,1,1,0,0,1);
        add(1,0,0,0,   MT,1,1,0,0,1);
        add(1,0,0,0,   MT,1,1,0,0,1);
        add(1,0,0,0,   MT,1,0,0,0,1);
        add(1,0,0,1,   7,1,0,0,0,0);
        add(1,0,0,0,   7,1,0,0,0,0);
        add(1,1,0,0,   0,1,0,0,1,0);
        add(1,0,0,0,   0,1,0,0,1,0);
        // game B: no hits, target swaps every 8 cycles, mid-game start ignored
        add(1,1,0,0,   MT,0,3,0,0,1);
        add(1,0,0,1,   MT,0,3,0,0,1);
        add(1,0,0,0,   MT,0,3,0,0,1);
        add(1,0,0,0,   MT,0,3,0,0,1);
        add(1,0,0,0,   MT,0,2,0,0,1);
        add(1,1,0,0,   MT,0,2,0,0,1);
        add(1,0,0,0,   MT,0,2,0,0,1);
        add(1,0,0,0,   MT,0,2,0,0,1);
        add(1,0,0,0,   MT,0,1,0,0,1);
        add(1,0,0,1,   MT,0,1,0,0,1);
        add(1,0,0,0,   MT,0,1,0,0,1);
        add(1,0,0,0,   MT,0,1,0,0,1);
        add(1,0,0,0,   MT,0,0,0,0,1);
        add(1,0,0,0,   7,0,0,0,0,0);
        add(1,1,0,0,   0,0,0,0,1,0);
        add(1,0,0,0,   0,0,0,0,1,0);
        // game C: wrong hits saturate at 0, then hit, then wrong hit, then reset
        add(1,1,0,0,   MT,0,3,0,0,1);
        add(1,0,0,1,   MT,0,3,0,0,1);
        add(1,0,WRG,0, MT,0,3,0,0,1);
        add(1,0,0,0,   MT,0,3,0,0,1);
        add(1,0,WRG,0, MT,0,2,0,0,1);
        add(1,0,0,0,   MT,0,2,0,0,1);
        add(1,0,TGT,0, MT,1,2,1,0,1);
        add(1,0,0,0,   MT,1,2,0,0,1);
        add(1,0,0,1,   MT,1,1,0,0,1);
        add(1,0,WRG,0, MT,0,1,0,0,1);
        add(1,0,0,0,   MT,0,1,0,0,1);
        add(0,0,0,0,   0,0,3,0,1,0);
        add(1,0,0,0,   0,0,3,0,1,0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst_n, tbl[i].start, tbl[i].box, tbl[i].arm);
            chk($sformatf("row%0d", i), tbl[i].mif, tbl[i].sc, tbl[i].tm,
                tbl[i].play, tbl[i].lobby, tbl[i].act);
        end

        // correct hit on the edge that ends the game: scored, pulsed, straight to game over
        cyc(1, 1, 0, 0);
        chk("last_start", MT, 0, 3, 0, 0, 1);
        cyc(1, 0, 0, 1);
        for (int k = 2; k <= 12; k++)
            cyc(1, 0, 0, k == 9);
        chk("last_t0", MT, 0, 0, 0, 0, 1);
        cyc(1, 0, TGT, 0);
        chk("last_hit", 7, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("last_after", 7, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk("last_lobby", 0, 1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0);

        // reset while waiting with score 2 and a correct box pending
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, TGT, 0);
        chk("rst_hit1", MT, 1, 3, 1, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, TGT, 0);
        chk("rst_hit2", MT, 2, 2, 1, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        chk("rst_wait", MT, 2, 2, 0, 0, 1);
        cyc(0, 0, TGT, 0);
        chk("rst_edge", 0, 0, 3, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("rst_after", 0, 0, 3, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000: CLOCK_50 cycles per one-second game tick.
REQ-002 Parameter GAME_SECONDS, default 60: game length in ticks, range 1..63.
REQ-003 Parameter TARGET_TICKS, default 2: ticks a target stays lit before it is replaced as a miss.
REQ-004 CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 start_game  in  1  level, sampled each cycle; a rising edge is a start request.
REQ-007 box_address  in  3  sensor box code: 0 = no hit, 1..6 = box struck, 7 = invalid and ignored.
REQ-008 mif_control_signal  out  3  screen select: 0 = lobby, 1..6 = lit target box, 7 = game-over screen.
REQ-009 score  out  11  unsigned hit score.
REQ-010 game_timer  out  6  seconds remaining.
REQ-011 play_sound  out  1  one-cycle pulse per correct hit.
REQ-012 lobby_sound  out  1  level, high while in LOBBY.
REQ-013 game_active  out  1  high in ARM, WAIT_HIT and HIT.

Function
REQ-014 FSM states: LOBBY, ARM, WAIT_HIT, HIT, GAME_OVER.
REQ-015 LOBBY: mif=0, lobby_sound=1; start edge -> ARM, score:=0, game_timer:=GAME_SECONDS, tick counter:=0.
REQ-016 ARM: one cycle; load target from LFSR per REQ-023, clear target-tick counter -> WAIT_HIT.
REQ-017 WAIT_HIT: mif=target; a new hit event (REQ-018) with box==target -> HIT; wrong box -> score decrements, saturating at 0, stay; TARGET_TICKS ticks elapsed -> ARM, score unchanged.
REQ-018 Hit event: box_address registered once (prev); event = box_address in 1..6 and box_address != prev; a held box counts once.
REQ-019 HIT: one cycle; play_sound=1; score increments, saturating at 2047 -> ARM.
REQ-020 Tick counter runs 0..TICK_DIV-1 only while game_active; on wrap, game_timer decrements.
REQ-021 game_timer reaching 0 -> GAME_OVER on the next edge from any active state. A hit event on the same edge is scored first: score updates, then HIT is skipped and play_sound still pulses.
REQ-022 GAME_OVER: mif=7; score and game_timer held; start edge -> LOBBY (score held until the next start from LOBBY).
REQ-023 Target selection: 8-bit Fibonacci LFSR, taps 8,6,5,4, steps every cycle. Candidate = lfsr[2:0]. If candidate is 0, 7, or equal to the current target, use (current target mod 6)+1, with current target 0 before the first ARM.
REQ-024 Start edges are ignored in ARM, WAIT_HIT and HIT.

Reset
REQ-025 On a clock edge with resetn=0: state=LOBBY, mif=0, score=0, game_timer=GAME_SECONDS, play_sound=0, lobby_sound=1, game_active=0, LFSR=8'hA5, prev box=0, start-edge register=0, counters=0.
REQ-026 Reset mid-game abandons the game with no further play_sound pulse; all outputs show reset values from the first cycle after the reset edge.

Structure
REQ-027 Package game_pkg holds the state encoding, MIF_LOBBY=0, MIF_GAMEOVER=7, NUM_BOXES=6, SCORE_MAX=2047.
REQ-028 One sub-module, target_lfsr: clock, resetn, 8-bit state output.
REQ-029 All outputs are registered; no combinational path from any input to any output.

Verification
Benches use TICK_DIV=4, GAME_SECONDS=3, TARGET_TICKS=2.
REQ-030 Reset then idle: mif=0, lobby_sound=1, score=0, game_timer=3.
REQ-031 Start, then box_address=target held for 5 cycles: exactly one play_sound pulse, score=1, new target != old target.
REQ-032 Start, then wrong box twice with 0 between: score stays 0 (saturation). Then a correct hit, then a wrong hit: score=0.
REQ-033 Start, no hits: target changes every 8 cycles, game_timer goes 3->2->1->0, mif=7 with score 0. Start edge -> mif=0.
REQ-034 Correct hit on the same edge game_timer reaches 0: score increments, play_sound pulses, next state GAME_OVER.
REQ-035 resetn=0 during WAIT_HIT with score=2: next cycle mif=0, score=0, no play_sound.
